// File: rtl/data_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package data_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned SIGN_BIT = 3;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 3'b001;
  localparam logic [SIZE_W-1:0] SZ_HALF = 3'b011;
  localparam logic [SIZE_W-1:0] SZ_WORD = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] sign_mask;
    logic              is_store;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [DATA_W-1:0] word_buf_i,
  input  logic [1:0]        lane_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] load_ext_o,
  output logic [DATA_W-1:0] store_merged_o,
  output logic              misaligned_o
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic              is_byte;
  logic              is_half;

  assign shamt   = {lane_i, 3'b000};
  assign shifted = word_buf_i >> shamt;
  assign is_byte = (size_i == SZ_BYTE);
  assign is_half = (size_i == SZ_HALF);

  // Any size encoding other than byte/half behaves as a full word.
  always_comb begin
    load_ext_o     = word_buf_i;
    store_merged_o = write_data_i;
    lane_mask      = '0;
    misaligned_o   = 1'b0;
    if (is_byte) begin
      load_ext_o     = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      lane_mask      = DATA_W'(32'h0000_00FF) << shamt;
      store_merged_o = (word_buf_i & ~lane_mask) |
                       ((write_data_i & DATA_W'(32'h0000_00FF)) << shamt);
    end else if (is_half) begin
      load_ext_o     = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      lane_mask      = DATA_W'(32'h0000_FFFF) << shamt;
      store_merged_o = (word_buf_i & ~lane_mask) |
                       ((write_data_i & DATA_W'(32'h0000_FFFF)) << shamt);
      misaligned_o   = (lane_i == 2'd3);
    end else begin
      misaligned_o   = (lane_i != 2'd0);
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 4-state access FSM over a word RAM with byte/half/word lanes.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [MASK_W-1:0] sign_mask,
  output logic [DATA_W-1:0] read_data,
  output logic              clk_stall,
  output logic              access_fault
);

  localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH_WORDS);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              access_fault_q, access_fault_d;
  logic [DATA_W-1:0] word_buf_q;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              req;
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              misaligned;
  logic              fault;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] store_merged;
  logic              rd_en;
  logic              mem_we;

  assign req          = memread | memwrite;
  assign off          = req_q.addr - BASE_ADDR;
  assign idx          = off[IDX_W+1:2];
  assign lane         = off[1:0];
  assign out_of_range = (req_q.addr < BASE_ADDR) || (off >= SPAN);
  assign fault        = out_of_range | misaligned;

  mem_lane_align u_align (
    .word_buf_i     (word_buf_q),
    .lane_i         (lane),
    .size_i         (req_q.sign_mask[SIZE_W-1:0]),
    .sign_i         (req_q.sign_mask[SIGN_BIT]),
    .write_data_i   (req_q.wdata),
    .load_ext_o     (load_ext),
    .store_merged_o (store_merged),
    .misaligned_o   (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DONE always returns to IDLE so a request still held by the CPU is not re-accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = FETCH;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_stall      = 1'b0;
    rd_en          = 1'b0;
    mem_we         = 1'b0;
    req_d          = req_q;
    read_data_d    = read_data_q;
    access_fault_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_stall = req;
        if (req) begin
          req_d.addr      = addr;
          req_d.wdata     = write_data;
          req_d.sign_mask = sign_mask;
          req_d.is_store  = memwrite;
        end
      end
      FETCH: begin
        clk_stall = 1'b1;
        rd_en     = 1'b1;
      end
      EXEC: begin
        clk_stall      = 1'b1;
        access_fault_d = fault;
        if (req_q.is_store) mem_we      = ~fault;
        else                read_data_d = fault ? '0 : load_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q          <= '0;
      read_data_q    <= '0;
      access_fault_q <= 1'b0;
    end else begin
      req_q          <= req_d;
      read_data_q    <= read_data_d;
      access_fault_q <= access_fault_d;
    end
  end

  // Array is not reset; writes only happen on the EXEC edge so a reset before it aborts the store.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= store_merged;
    if (rd_en)  word_buf_q <= mem_q[idx];
  end

  assign read_data    = read_data_q;
  assign access_fault = access_fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        access_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] rd;
  logic        flt;
  int          stalls;
  logic        early;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .write_data   (write_data),
    .memwrite     (memwrite),
    .memread      (memread),
    .sign_mask    (sign_mask),
    .read_data    (read_data),
    .clk_stall    (clk_stall),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  // Drives one request, counts stall cycles and samples outputs in the DONE cycle.
  task automatic access(input logic st, input logic ld, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] rdata, output logic flt_o,
                        output int stall_n, output logic early_o);
    logic done;
    addr = a; write_data = wd; sign_mask = m; memwrite = st; memread = ld;
    stall_n = 0; early_o = 1'b0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk_stall) begin
        stall_n++;
        if (access_fault) early_o = 1'b1;
      end else begin
        done = 1'b1;
        break;
      end
    end
    rdata = read_data;
    flt_o = access_fault;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_timeout addr=%h: clk_stall still high after 20 cycles", a);
    end
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memwrite = 1'b0; memread = 1'b0;
    addr = '0; write_data = '0; sign_mask = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data got=%h exp=00000000", read_data); end
    n_cmp++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", access_fault); end
    n_cmp++; if (clk_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_noreq got=%b exp=0", clk_stall); end
    memread = 1'b1; #1;
    n_cmp++; if (clk_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req got=%b exp=1", clk_stall); end
    memread = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    access(1'b1, 1'b0, 32'h1004, 32'hDEADBEEF, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL word_store_stalls got=%0d exp=3", stalls); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL word_store_rd_hold got=%h exp=00000000", rd); end
    n_cmp++; if (flt !== 1'b0) begin n_fail++; $display("FAIL word_store_fault got=%b exp=0", flt); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL word_load_stalls got=%0d exp=3", stalls); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_half_load();
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b1001, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL byte0_signed got=%h exp=ffffffef", rd); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0001, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h000000EF) begin n_fail++; $display("FAIL byte0_unsigned got=%h exp=000000ef", rd); end
    access(1'b0, 1'b1, 32'h1006, 32'h0, 4'b1001, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'hFFFFFFAD) begin n_fail++; $display("FAIL byte2_signed got=%h exp=ffffffad", rd); end
    access(1'b0, 1'b1, 32'h1006, 32'h0, 4'b1011, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL half2_signed got=%h exp=ffffdead", rd); end
    access(1'b0, 1'b1, 32'h1005, 32'h0, 4'b0011, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h0000ADBE) begin n_fail++; $display("FAIL half1_unsigned got=%h exp=0000adbe", rd); end
    n_cmp++; if (flt !== 1'b0) begin n_fail++; $display("FAIL half1_fault got=%b exp=0", flt); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b1000, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL size000_as_word got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_store_merge();
    access(1'b1, 1'b0, 32'h1006, 32'h00001234, 4'b0011, rd, flt, stalls, early);
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL half_rmw got=%h exp=1234beef", rd); end
    access(1'b1, 1'b0, 32'h1005, 32'hFFFFFF55, 4'b0001, rd, flt, stalls, early);
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL byte_rmw got=%h exp=123455ef", rd); end
  endtask

  task automatic test_faults();
    access(1'b0, 1'b1, 32'h1002, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_load_rd got=%h exp=00000000", rd); end
    n_cmp++; if (flt !== 1'b1) begin n_fail++; $display("FAIL misaligned_load_fault got=%b exp=1", flt); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL fault_early got=%b exp=0", early); end
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL fault_stalls got=%0d exp=3", stalls); end
    @(negedge clk);
    n_cmp++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL fault_pulse_width got=%b exp=0", access_fault); end
    @(posedge clk); #1;
    // Seed the words an out-of-range index would alias onto.
    access(1'b1, 1'b0, 32'h1FFC, 32'h11223344, 4'b0111, rd, flt, stalls, early);
    access(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 4'b0111, rd, flt, stalls, early);
    access(1'b1, 1'b0, 32'h0FFC, 32'hA5A5A5A5, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (flt !== 1'b1) begin n_fail++; $display("FAIL below_base_fault got=%b exp=1", flt); end
    access(1'b1, 1'b0, 32'h2000, 32'h5A5A5A5A, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (flt !== 1'b1) begin n_fail++; $display("FAIL above_top_fault got=%b exp=1", flt); end
    access(1'b1, 1'b0, 32'h1007, 32'h0000FFFF, 4'b0011, rd, flt, stalls, early);
    n_cmp++; if (flt !== 1'b1) begin n_fail++; $display("FAIL half_lane3_fault got=%b exp=1", flt); end
    access(1'b0, 1'b1, 32'h1FFC, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL below_base_unchanged got=%h exp=11223344", rd); end
    access(1'b0, 1'b1, 32'h1000, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL above_top_unchanged got=%h exp=cafef00d", rd); end
    access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL misaligned_store_unchanged got=%h exp=123455ef", rd); end
  endtask

  task automatic test_reset_mid_store();
    access(1'b1, 1'b0, 32'h1008, 32'h0BADF00D, 4'b0111, rd, flt, stalls, early);
    access(1'b0, 1'b1, 32'h1008, 32'h0, 4'b0111, rd, flt, stalls, early);
    addr = 32'h1008; write_data = 32'hFFFFFFFF; sign_mask = 4'b0111; memwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (clk_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall got=%b exp=1", clk_stall); end
    rst_n = 1'b0; #1;
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL midreset_rd got=%h exp=00000000", read_data); end
    n_cmp++; if (clk_stall !== 1'b1) begin n_fail++; $display("FAIL midreset_stall_req got=%b exp=1", clk_stall); end
    memwrite = 1'b0; #1;
    n_cmp++; if (clk_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall_noreq got=%b exp=0", clk_stall); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h1008, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL midreset_word_unchanged got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_held_and_both();
    access(1'b1, 1'b1, 32'h100C, 32'h77665544, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL both_ops_rd_hold got=%h exp=0badf00d", rd); end
    @(negedge clk);
    n_cmp++; if (clk_stall !== 1'b0) begin n_fail++; $display("FAIL no_reaccept got=%b exp=0", clk_stall); end
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h100C, 32'h0, 4'b0111, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h77665544) begin n_fail++; $display("FAIL both_ops_stored got=%h exp=77665544", rd); end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'h100C, 32'h0, 4'b1001, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h00000044) begin n_fail++; $display("FAIL b2b_first got=%h exp=00000044", rd); end
    access(1'b0, 1'b1, 32'h100F, 32'h0, 4'b0001, rd, flt, stalls, early);
    n_cmp++; if (rd !== 32'h00000077) begin n_fail++; $display("FAIL b2b_second got=%h exp=00000077", rd); end
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=3", stalls); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half_load();
    test_store_merge();
    test_faults();
    test_reset_mid_store();
    test_held_and_both();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder for the CPU data-memory interface: accepts load/store requests and returns load data.
- Requests arrive as address, write data, memwrite, memread and sign_mask.
- Holds a word-organised synchronous RAM and performs byte/halfword/word access with little-endian lanes.
- Stores use read-modify-write; loads are sign- or zero-extended.
- Holds the pipeline via clk_stall until each access completes.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_1000, byte address of word 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  byte address.
- write_data  input  32  store data, right-aligned.
- memwrite  input  1  store request.
- memread  input  1  load request.
- sign_mask  input  4  bit3 = sign-extend load; bits[2:0] = size: 001 byte, 011 half, 111 word.
- read_data  output  32  extended load result.
- clk_stall  output  1  high while the current request is not complete; CPU holds all inputs stable while high.
- access_fault  output  1  one-cycle pulse when an access is misaligned or out of range.

Behaviour:
- Reset, asynchronous, rst_n low:
  - state=IDLE, read_data=0, access_fault=0, latched request registers=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the access; a store not yet past its EXEC edge is never written.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - req = memread|memwrite.
  - On a clock edge with req: latch addr, write_data, sign_mask and op (store if memwrite, else load); go to FETCH.
  - memwrite and memread both high is treated as a store.
- FETCH: array read at the latched word index; word_buf <= mem[idx]; go to EXEC.
- EXEC, load:
  - read_data <= extended lane extract.
- EXEC, store:
  - mem[idx] <= word_buf with the selected byte lanes replaced.
  - read_data is unchanged.
- EXEC, both ops: go to DONE.
- DONE:
  - clk_stall low; the CPU advances on this edge.
  - Request inputs are ignored.
  - Go to IDLE unconditionally, which prevents re-acceptance of the held request.
- clk_stall (combinational) = (state==IDLE & req) | state==FETCH | state==EXEC. It is low in DONE and in IDLE without req.
- Latency: request accepted at edge N; read_data valid after edge N+2; CPU samples it at edge N+3. Back-to-back requests are accepted in IDLE on the edge after DONE.
- Index: off = addr - BASE_ADDR; idx = off[2+log2(DEPTH_WORDS)-1:2]; lane = off[1:0].
- Out of range: addr < BASE_ADDR or off >= 4*DEPTH_WORDS.
- Misaligned: half with lane==3; word with lane!=0. Byte accesses are never misaligned.
- Fault (out of range or misaligned):
  - Load returns read_data=0.
  - Store leaves the array unchanged.
  - access_fault=1 during the DONE cycle only.
  - Timing is the same as a normal access.
- Load extract: word_buf >> (8*lane), masked to size. If bit3 is set, sign-extend from bit 7 (byte) or bit 15 (half); otherwise zero-extend. Word loads ignore bit3.
- Store merge:
  - Byte writes write_data[7:0] to lane.
  - Half writes write_data[15:0] to lanes lane, lane+1.
  - Word writes all 32 bits.
- Unsupported size encodings (000, 010, 1xx other than 111) are treated as word.
- read_data holds its value until the next completed load or reset.

Decomposition:
- Package data_mem_pkg:
  - State enum: IDLE, FETCH, EXEC, DONE.
  - Size constants: SZ_BYTE=3'b001, SZ_HALF=3'b011, SZ_WORD=3'b111.
  - Sign bit index 3.
- Sub-module mem_lane_align (combinational):
  - Inputs: word_buf, lane, size, sign, write_data.
  - Outputs: load_ext, store_merged, misaligned.
- Top level holds the FSM, array and fault logic.

Test Plan:
- Word store then load: store 32'hDEADBEEF at 0x1004 size 111; load 0x1004 → read_data=32'hDEADBEEF; clk_stall high for 3 cycles per access, low in DONE.
- Signed/unsigned byte: after the word above, load byte 0x1004 sign=1 → 32'hFFFFFFEF; sign=0 → 32'h000000EF; lane 2 sign=1 → 32'hFFFFFFAD.
- Half store RMW: store half 32'h00001234 at 0x1006 over DEADBEEF; word load → 32'h1234BEEF.
- Faults:
  - Word load at 0x1002 → read_data=0, one-cycle access_fault.
  - Store at 0x0FFC → array unchanged, access_fault pulse.
  - Store at BASE_ADDR+4*DEPTH_WORDS → array unchanged, access_fault pulse.
- Reset mid-store: assert rst_n=0 in FETCH of a store to 0x1008 → word unchanged, read_data=0, state IDLE, clk_stall follows req only.
- Held request and both ops: keep memread high through DONE → exactly one access per request; memread=memwrite=1 → performs a store, read_data unchanged.
